// File: rtl/cpu_clk_pkg.sv
// Shared state encoding and default divisors for the CPU clock sequencer.
package cpu_clk_pkg;

  localparam int unsigned STATE_WIDTH       = 2;
  localparam int unsigned SLOW_DIV_DEFAULT  = 50_000_000;
  localparam int unsigned FAST_DIV_DEFAULT  = 100_000;
  localparam int unsigned DIV_WIDTH_DEFAULT = 27;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BURST  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // States in which the rate divider is counting.
  function automatic logic is_active(input state_t s);
    return (s == ST_RUN) || (s == ST_BURST);
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Divider producing a tick every curDiv cycles; curDiv picked by speed_sel.
module rate_tick_gen
  import cpu_clk_pkg::*;
#(
  parameter int unsigned SLOW_DIV  = SLOW_DIV_DEFAULT,
  parameter int unsigned FAST_DIV  = FAST_DIV_DEFAULT,
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic speed_sel,
  output logic tick_c
);

  localparam logic [DIV_WIDTH-1:0] SLOW_LAST = DIV_WIDTH'(SLOW_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] FAST_LAST = DIV_WIDTH'(FAST_DIV - 1);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] last_c;

  // >= compare lets a mid-run switch to a smaller divisor tick right away.
  assign last_c = speed_sel ? FAST_LAST : SLOW_LAST;
  assign tick_c = (div_q >= last_c);

  // Divider counter: clears on request or on tick, otherwise increments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (clear || tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_clk_sequencer.sv
// CPU clock-enable sequencer: single step, free run and fixed-length bursts.
module cpu_clk_sequencer
  import cpu_clk_pkg::*;
#(
  parameter int unsigned SLOW_DIV    = SLOW_DIV_DEFAULT,
  parameter int unsigned FAST_DIV    = FAST_DIV_DEFAULT,
  parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEFAULT,
  parameter int unsigned BURST_WIDTH = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   BasysCLK,
  input  logic                   Reset,
  input  logic                   StepPulse,
  input  logic                   RunToggle,
  input  logic                   BurstStart,
  input  logic [BURST_WIDTH-1:0] BurstLen,
  input  logic                   SpeedSel,
  input  logic                   Halt,
  output logic                   CPUCLK,
  output logic                   Running,
  output logic [STATE_WIDTH-1:0] State,
  output logic [CNT_WIDTH-1:0]   CycleCount
);

  state_t                 state_q;
  state_t                 state_d;
  logic [BURST_WIDTH-1:0] remaining_q;
  logic                   tick_c;
  logic                   div_clear_c;
  logic                   pulse_c;
  logic                   load_burst_c;
  logic                   dec_burst_c;
  logic                   burst_valid_c;
  logic                   last_burst_c;

  assign burst_valid_c = (BurstLen != '0);
  assign last_burst_c  = (remaining_q == BURST_WIDTH'(1));

  rate_tick_gen #(
    .SLOW_DIV  (SLOW_DIV),
    .FAST_DIV  (FAST_DIV),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_rate_tick_gen (
    .clk       (BasysCLK),
    .rst       (Reset),
    .clear     (div_clear_c),
    .speed_sel (SpeedSel),
    .tick_c    (tick_c)
  );

  // State register.
  always_ff @(posedge BasysCLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; RunToggle always wins, then Halt, then tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (RunToggle) begin
          state_d = ST_RUN;
        end else if (BurstStart && burst_valid_c) begin
          state_d = ST_BURST;
        end
      end
      ST_RUN: begin
        if (RunToggle) begin
          state_d = ST_IDLE;
        end else if (Halt) begin
          state_d = ST_HALTED;
        end
      end
      ST_BURST: begin
        if (RunToggle) begin
          state_d = ST_IDLE;
        end else if (Halt) begin
          state_d = ST_HALTED;
        end else if (tick_c && last_burst_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (RunToggle) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: pulse request, burst load/decrement, divider clear.
  always_comb begin
    pulse_c      = 1'b0;
    load_burst_c = 1'b0;
    dec_burst_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!RunToggle) begin
          if (BurstStart) begin
            load_burst_c = burst_valid_c;
          end else if (StepPulse) begin
            pulse_c = 1'b1;
          end
        end
      end
      ST_RUN: begin
        pulse_c = tick_c && !RunToggle && !Halt;
      end
      ST_BURST: begin
        pulse_c     = tick_c && !RunToggle && !Halt;
        dec_burst_c = tick_c && !RunToggle && !Halt;
      end
      default: ;
    endcase
    // Divider restarts on every state entry and idles outside RUN/BURST.
    div_clear_c = !is_active(state_q) || (state_d != state_q);
  end

  // Burst remaining-count; discarded whenever BURST is left.
  always_ff @(posedge BasysCLK or posedge Reset) begin
    if (Reset) begin
      remaining_q <= '0;
    end else if (load_burst_c) begin
      remaining_q <= BurstLen;
    end else if (state_d != ST_BURST) begin
      remaining_q <= '0;
    end else if (dec_burst_c) begin
      remaining_q <= remaining_q - BURST_WIDTH'(1);
    end
  end

  // Registered outputs; Running is aligned with the state register.
  always_ff @(posedge BasysCLK or posedge Reset) begin
    if (Reset) begin
      CPUCLK     <= 1'b0;
      Running    <= 1'b0;
      CycleCount <= '0;
    end else begin
      CPUCLK     <= pulse_c;
      Running    <= is_active(state_d);
      CycleCount <= CycleCount + CNT_WIDTH'(pulse_c);
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_cpu_clk_sequencer.sv
// Self-checking bench for cpu_clk_sequencer with a cycle-level reference model.
module tb_cpu_clk_sequencer;

  localparam int unsigned SLOW = 4;
  localparam int unsigned FAST = 2;
  localparam int unsigned BW   = 4;
  localparam int unsigned CW   = 4;

  logic          clk;
  logic          Reset;
  logic          StepPulse;
  logic          RunToggle;
  logic          BurstStart;
  logic [BW-1:0] BurstLen;
  logic          SpeedSel;
  logic          Halt;
  logic          CPUCLK;
  logic          Running;
  logic [1:0]    State;
  logic [CW-1:0] CycleCount;

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0..3, cycles waited since entry/last pulse,
  // pulses left in a burst, pulse count, and expected CPUCLK.
  int m_mode;
  int m_wait;
  int m_left;
  int m_cnt;
  int m_clk;

  cpu_clk_sequencer #(
    .SLOW_DIV    (SLOW),
    .FAST_DIV    (FAST),
    .DIV_WIDTH   (3),
    .BURST_WIDTH (BW),
    .CNT_WIDTH   (CW)
  ) dut (
    .BasysCLK   (clk),
    .Reset      (Reset),
    .StepPulse  (StepPulse),
    .RunToggle  (RunToggle),
    .BurstStart (BurstStart),
    .BurstLen   (BurstLen),
    .SpeedSel   (SpeedSel),
    .Halt       (Halt),
    .CPUCLK     (CPUCLK),
    .Running    (Running),
    .State      (State),
    .CycleCount (CycleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_wait = 0;
    m_left = 0;
    m_cnt  = 0;
    m_clk  = 0;
  endtask

  // One BasysCLK cycle of the behavioural rules, using the inputs now applied.
  task automatic model_eval();
    int div;
    int nmode;
    int pulse;
    bit due;
    div   = SpeedSel ? int'(FAST) : int'(SLOW);
    due   = (m_wait + 1 >= div);
    pulse = 0;
    nmode = m_mode;
    case (m_mode)
      0: begin
        if (RunToggle) nmode = 1;
        else if (BurstStart) begin
          if (BurstLen != 0) begin
            nmode  = 2;
            m_left = int'(BurstLen);
          end
        end else if (StepPulse) pulse = 1;
      end
      1: begin
        if (RunToggle) nmode = 0;
        else if (Halt) nmode = 3;
        else if (due) pulse = 1;
      end
      2: begin
        if (RunToggle) nmode = 0;
        else if (Halt) nmode = 3;
        else if (due) begin
          pulse = 1;
          m_left--;
          if (m_left == 0) nmode = 0;
        end
      end
      default: if (RunToggle) nmode = 0;
    endcase
    if (nmode != 2) m_left = 0;
    if (nmode != m_mode || !(nmode == 1 || nmode == 2) || due) m_wait = 0;
    else m_wait++;
    m_mode = nmode;
    m_clk  = pulse;
    m_cnt  = (m_cnt + pulse) % (1 << CW);
  endtask

  // Advance one clock and compare every output with the model.
  task automatic cycle();
    model_eval();
    @(posedge clk);
    #1;
    chk("cpuclk",  16'(CPUCLK),     16'(m_clk));
    chk("state",   16'(State),      16'(m_mode));
    chk("running", 16'(Running),    16'((m_mode == 1) || (m_mode == 2)));
    chk("count",   16'(CycleCount), 16'(m_cnt));
  endtask

  task automatic drive(input logic sp, input logic rt, input logic bs, input logic [BW-1:0] bl);
    StepPulse  = sp;
    RunToggle  = rt;
    BurstStart = bs;
    BurstLen   = bl;
    cycle();
    StepPulse  = 1'b0;
    RunToggle  = 1'b0;
    BurstStart = 1'b0;
  endtask

  initial begin
    int pulses;
    int last_idx;
    Reset      = 1'b1;
    StepPulse  = 1'b0;
    RunToggle  = 1'b0;
    BurstStart = 1'b0;
    BurstLen   = '0;
    SpeedSel   = 1'b0;
    Halt       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cpuclk",  16'(CPUCLK),     16'd0);
    chk("reset_state",   16'(State),      16'd0);
    chk("reset_running", 16'(Running),    16'd0);
    chk("reset_count",   16'(CycleCount), 16'd0);
    Reset = 1'b0;

    // Single step after idle cycles.
    repeat (8) cycle();
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("step_pulse", 16'(CPUCLK), 16'd1);
    chk("step_count", 16'(CycleCount), 16'd1);
    cycle();
    chk("step_single_wide", 16'(CPUCLK), 16'd0);

    // Free run at the slow rate, five pulses, then stop.
    SpeedSel = 1'b0;
    drive(1'b0, 1'b1, 1'b0, '0);
    pulses   = 0;
    last_idx = 0;
    for (int i = 1; i <= 40 && pulses < 5; i++) begin
      cycle();
      if (CPUCLK === 1'b1) begin
        pulses++;
        chk("run_pulse_spacing", 16'(i - last_idx), 16'd4);
        last_idx = i;
      end
    end
    chk("run_pulses", 16'(pulses), 16'd5);
    drive(1'b0, 1'b1, 1'b0, '0);
    chk("run_stop_state", 16'(State), 16'd0);
    repeat (8) cycle();
    chk("count_after_run", 16'(CycleCount), 16'd6);

    // Burst of 3 at the fast rate.
    SpeedSel = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 4'd3);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (CPUCLK === 1'b1) pulses++;
    end
    chk("burst_pulses",  16'(pulses),  16'd3);
    chk("burst_state",   16'(State),   16'd0);
    chk("burst_running", 16'(Running), 16'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    chk("burst_zero_state", 16'(State), 16'd0);

    // Halt arriving on the tick cycle in RUN.
    SpeedSel = 1'b0;
    drive(1'b0, 1'b1, 1'b0, '0);
    repeat (3) cycle();
    Halt = 1'b1;
    cycle();
    chk("halt_state", 16'(State),  16'd3);
    chk("halt_nopulse", 16'(CPUCLK), 16'd0);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("halt_step_ignored", 16'(CPUCLK), 16'd0);
    drive(1'b0, 1'b1, 1'b0, '0);
    chk("halt_exit_state", 16'(State), 16'd0);
    Halt = 1'b0;

    // All three requests together: RunToggle has priority.
    drive(1'b1, 1'b1, 1'b1, 4'd5);
    chk("prio_state",  16'(State),  16'd1);
    chk("prio_nopulse", 16'(CPUCLK), 16'd0);
    drive(1'b0, 1'b1, 1'b0, '0);

    // Asynchronous reset in the middle of a burst.
    SpeedSel = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 4'd4);
    repeat (4) cycle();
    chk("midburst_state", 16'(State), 16'd2);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_cpuclk",  16'(CPUCLK),     16'd0);
    chk("async_state",   16'(State),      16'd0);
    chk("async_running", 16'(Running),    16'd0);
    chk("async_count",   16'(CycleCount), 16'd0);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    model_reset();
    cycle();
    chk("post_reset_nopulse", 16'(CPUCLK), 16'd0);

    // Counter wrap after 17 steps.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      cycle();
    end
    chk("count_wrap", 16'(CycleCount), 16'd1);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) SpeedSel = ~SpeedSel;
      if ($urandom_range(0, 11) == 0) Halt = ~Halt;
      drive(1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 13) == 0),
            1'($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
